// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bus between an initiator and mem_responder
interface mem_responder_if;
    logic        request_valid;
    logic        request_ready;
    logic [31:0] address;
    logic [31:0] input_data;
    logic        should_write;
    logic        response_valid;
    logic        response_ready;
    logic [31:0] output_data;
    logic        error;

    modport master (
        output request_valid, address, input_data, should_write, response_ready,
        input  request_ready, response_valid, output_data, error
    );

    modport slave (
        input  request_valid, address, input_data, should_write, response_ready,
        output request_ready, response_valid, output_data, error
    );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency word memory responder; optional MEM_RESPONDER_RANGE_CHECK_EN
module mem_responder #(
    parameter int MEMORY_WORDS = 256,
    parameter int LATENCY      = 4
) (
    input logic           clock,
    input logic           reset,
    mem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(MEMORY_WORDS);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESPOND} state_t;

    state_t      r_state;
    logic [3:0]  r_count;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_write;
    logic [31:0] r_mem [MEMORY_WORDS];
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        r_err;

    logic             w_accept;
    logic             w_fire;
    logic [31:0]      w_acc_addr;
    logic [31:0]      w_acc_data;
    logic             w_acc_write;
    logic [IDX_W-1:0] w_index;
    logic             w_oor;
    logic             w_unused_addr;

    assign w_accept = (r_state == ST_IDLE) && bus.request_valid;
    // With LATENCY=1 the access happens on the acceptance edge, before the latches hold the request
    assign w_fire = (w_accept && (LATENCY == 1)) || ((r_state == ST_WAIT) && (r_count == 4'd1));

    assign w_acc_addr  = (r_state == ST_IDLE) ? bus.address      : r_addr;
    assign w_acc_data  = (r_state == ST_IDLE) ? bus.input_data   : r_wdata;
    assign w_acc_write = (r_state == ST_IDLE) ? bus.should_write : r_write;
    assign w_index     = w_acc_addr[IDX_W+1:2];

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    assign w_oor = (w_acc_addr >= 32'(MEMORY_WORDS * 4));
`else
    assign w_oor = 1'b0;
`endif

    assign w_unused_addr = ^{w_acc_addr[1:0], w_acc_addr[31:IDX_W+2]};

    assign bus.request_ready  = (r_state == ST_IDLE);
    assign bus.response_valid = r_rvalid;
    assign bus.output_data    = r_rdata;
    assign bus.error          = r_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_count  <= 4'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_write  <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
            for (int i = 0; i < MEMORY_WORDS; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.request_valid) begin
                        r_addr  <= bus.address;
                        r_wdata <= bus.input_data;
                        r_write <= bus.should_write;
                        if (LATENCY == 1) begin
                            r_state  <= ST_RESPOND;
                            r_rvalid <= 1'b1;
                        end else begin
                            r_count <= 4'(LATENCY - 1);
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    r_count <= r_count - 4'd1;
                    if (r_count == 4'd1) begin
                        r_state  <= ST_RESPOND;
                        r_rvalid <= 1'b1;
                    end
                end
                ST_RESPOND: begin
                    if (bus.response_ready) begin
                        r_state  <= ST_IDLE;
                        r_rvalid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_fire) begin
                if (w_oor) begin
                    r_rdata <= 32'd0;
                    r_err   <= 1'b1;
                end else if (w_acc_write) begin
                    r_mem[w_index] <= w_acc_data;
                    r_rdata        <= w_acc_data;
                    r_err          <= 1'b0;
                end else begin
                    r_rdata <= r_mem[w_index];
                    r_err   <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder at LATENCY 4 and LATENCY 1
module tb_mem_responder;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] m4 [256];
    logic [31:0] m1 [256];

    mem_responder_if bus4();
    mem_responder_if bus1();

    mem_responder #(.MEMORY_WORDS(256), .LATENCY(4)) dut4 (.clock(clock), .reset(reset), .bus(bus4));
    mem_responder #(.MEMORY_WORDS(256), .LATENCY(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input bit sel, input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            bus1.request_valid = v; bus1.should_write = w; bus1.address = a; bus1.input_data = d;
        end else begin
            bus4.request_valid = v; bus4.should_write = w; bus4.address = a; bus4.input_data = d;
        end
    endtask

    task automatic set_rready(input bit sel, input logic v);
        if (sel) bus1.response_ready = v; else bus4.response_ready = v;
    endtask

    function automatic logic get_rv(input bit sel);
        return sel ? bus1.response_valid : bus4.response_valid;
    endfunction
    function automatic logic get_rq(input bit sel);
        return sel ? bus1.request_ready : bus4.request_ready;
    endfunction
    function automatic logic [31:0] get_rd(input bit sel);
        return sel ? bus1.output_data : bus4.output_data;
    endfunction
    function automatic logic get_err(input bit sel);
        return sel ? bus1.error : bus4.error;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) begin
            m4[i] = 32'd0;
            m1[i] = 32'd0;
        end
    endtask

    // Reference behaviour: word index is the byte address divided by 4, wrapped to the memory size
    task automatic model_access(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] exp_d, output logic exp_e);
        int idx;
        idx = int'((a / 4) % 256);
        if (RC && a >= 32'd1024) begin
            exp_d = 32'd0;
            exp_e = 1'b1;
        end else begin
            exp_e = 1'b0;
            if (w) begin
                if (sel) m1[idx] = d; else m4[idx] = d;
                exp_d = d;
            end else begin
                exp_d = sel ? m1[idx] : m4[idx];
            end
        end
    endtask

    task automatic txn(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d, input string tag);
        logic [31:0] exp_d;
        logic        exp_e;
        int          k;
        @(negedge clock);
        drive_req(sel, 1'b1, w, a, d);
        check({tag, "_req_ready"}, 32'(get_rq(sel)), 32'd1);
        @(posedge clock);
        #1 drive_req(sel, 1'b0, 1'($urandom), $urandom, $urandom);
        model_access(sel, w, a, d, exp_d, exp_e);
        k = 1;
        while (k < 40) begin
            @(negedge clock);
            if (get_rv(sel)) break;
            set_rready(sel, 1'($urandom));
            k++;
            @(posedge clock);
        end
        set_rready(sel, 1'b1);
        check({tag, "_latency"}, 32'(k), sel ? 32'd1 : 32'd4);
        check({tag, "_data"}, get_rd(sel), exp_d);
        check({tag, "_error"}, 32'(get_err(sel)), 32'(exp_e));
        @(posedge clock);
        @(negedge clock);
        check({tag, "_rv_drop"}, 32'(get_rv(sel)), 32'd0);
        check({tag, "_ready_back"}, 32'(get_rq(sel)), 32'd1);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) a = a + 32'h400 * 32'($urandom_range(1, 7));
        return a;
    endfunction

    initial begin
        logic [31:0] exp_d;
        logic        exp_e;
        int          k;

        drive_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        set_rready(1'b0, 1'b1);
        set_rready(1'b1, 1'b1);
        model_clear();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        check("rst_req_ready4", 32'(bus4.request_ready), 32'd1);
        check("rst_rv4", 32'(bus4.response_valid), 32'd0);
        check("rst_data4", bus4.output_data, 32'd0);
        check("rst_err4", 32'(bus4.error), 32'd0);
        check("rst_rv1", 32'(bus1.response_valid), 32'd0);
        check("rst_data1", bus1.output_data, 32'd0);

        txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "wr_10");
        txn(1'b0, 1'b0, 32'h10, 32'h0, "rd_10");

        for (int i = 0; i < 12; i++) begin
            txn(1'b0, 1'($urandom_range(0, 1)), rand_addr(), $urandom, "rand4");
        end

        // Response held back by the initiator while a stray request is presented
        @(negedge clock);
        drive_req(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
        @(posedge clock);
        #1 drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        bus4.response_ready = 1'b0;
        model_access(1'b0, 1'b0, 32'h20, 32'h0, exp_d, exp_e);
        k = 1;
        while (k < 40) begin
            @(negedge clock);
            if (bus4.response_valid) break;
            k++;
            @(posedge clock);
        end
        check("hold_latency", 32'(k), 32'd4);
        for (int i = 0; i < 5; i++) begin
            check("hold_rv", 32'(bus4.response_valid), 32'd1);
            check("hold_data", bus4.output_data, exp_d);
            check("hold_req_ready", 32'(bus4.request_ready), 32'd0);
            drive_req(1'b0, 1'b1, 1'b1, 32'h20, $urandom | 32'h1);
            @(posedge clock);
            @(negedge clock);
        end
        drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        bus4.response_ready = 1'b1;
        check("hold_data_end", bus4.output_data, exp_d);
        @(posedge clock);
        txn(1'b0, 1'b0, 32'h20, 32'h0, "rd_20_after_hold");

        // Reset two cycles after accepting a write: the write must be lost
        @(negedge clock);
        drive_req(1'b0, 1'b1, 1'b1, 32'h40, 32'h12345678);
        @(posedge clock);
        #1 drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        check("midrst_rv", 32'(bus4.response_valid), 32'd0);
        check("midrst_ready", 32'(bus4.request_ready), 32'd1);
        txn(1'b0, 1'b0, 32'h40, 32'h0, "rd_40_after_rst");
        txn(1'b0, 1'b0, 32'h10, 32'h0, "rd_10_after_rst");

        txn(1'b1, 1'b0, 32'h0, 32'h0, "l1_rd_0");
        for (int i = 0; i < 6; i++) begin
            txn(1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, "rand1");
        end

        txn(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, "wr_400");
        txn(1'b0, 1'b0, 32'h0, 32'h0, "rd_0_after_400");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter MEMORY_WORDS, default 256, number of 32-bit words stored (power of two).
REQ-002 SHALL have parameter LATENCY, default 4, cycles from request acceptance to response_valid (legal range 1..15).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port request_valid  input  1  initiator presents a request.
REQ-006 SHALL have port request_ready  output  1  responder can accept a request.
REQ-007 SHALL have port address  input  32  byte address; bits [1:0] ignored.
REQ-008 SHALL have port input_data  input  32  write data.
REQ-009 SHALL have port should_write  input  1  1 = write, 0 = read.
REQ-010 SHALL have port response_valid  output  1  response available on output_data/error.
REQ-011 SHALL have port response_ready  input  1  initiator accepts the response.
REQ-012 SHALL have port output_data  output  32  read data, or echoed write data.
REQ-013 SHALL have port error  output  1  response flags an out-of-range access.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESPOND; request_ready = 1 only in IDLE.
REQ-015 SHALL accept a request on a posedge where state = IDLE and request_valid = 1, latching address, input_data and should_write.
REQ-016 SHALL, on acceptance with LATENCY > 1, load a down-counter with LATENCY-1 and enter WAIT; with LATENCY = 1, perform the access and enter RESPOND directly.
REQ-017 SHALL decrement the counter in WAIT; on the edge where it reaches 0, perform the access and enter RESPOND.
REQ-018 SHALL assert response_valid exactly LATENCY cycles after the acceptance edge.
REQ-019 SHALL index storage with latched address[log2(MEMORY_WORDS)+1:2].
REQ-020 SHALL, for a read, load output_data with the stored word; for a write, commit input_data to storage and load output_data with input_data.
REQ-021 SHALL hold response_valid, output_data and error stable in RESPOND until a posedge with response_ready = 1, then return to IDLE.
REQ-022 SHALL ignore request_valid, address, input_data and should_write outside IDLE.
REQ-023 SHALL require one IDLE cycle between consecutive transactions; minimum transaction period is LATENCY+1 cycles with response_ready held high.
REQ-024 SHALL ignore response_ready outside RESPOND.

Reset
REQ-025 SHALL, on any posedge with reset = 1, enter IDLE and clear the counter, response_valid, output_data and error to 0.
REQ-026 SHALL clear all storage words to 0 on reset.
REQ-027 SHALL, on reset during WAIT, discard the pending request; a pending write SHALL NOT be committed.
REQ-028 SHALL, on reset during RESPOND, drop the response with no handshake.

Configuration
REQ-029 SHALL honour macro MEM_RESPONDER_RANGE_CHECK_EN.
REQ-030 With the macro defined, SHALL flag any latched address >= MEMORY_WORDS*4: no storage update, output_data = 0, error = 1 in the response.
REQ-031 Without the macro, SHALL ignore upper address bits (index wraps modulo MEMORY_WORDS) and tie error to 0.

Verification
REQ-032 SHALL cover: LATENCY=4, write 0xDEADBEEF to 0x10, then read 0x10 -> each response_valid rises 4 cycles after acceptance; read returns 0xDEADBEEF, error=0.
REQ-033 SHALL cover: read 0x20 accepted, response_ready held 0 for 5 cycles -> output_data and response_valid stable; request_ready=0 throughout; a new request_valid during this time is ignored.
REQ-034 SHALL cover: write 0x12345678 to 0x40, reset asserted 2 cycles after acceptance, then read 0x40 -> returns 0x00000000.
REQ-035 SHALL cover: LATENCY=1, read after reset -> response_valid on the edge after acceptance, output_data=0.
REQ-036 SHALL cover: MEMORY_WORDS=256, write 0xA5A5A5A5 to 0x400 -> with macro, error=1, output_data=0 and word 0 unchanged; without macro, error=0 and a read of 0x0 returns 0xA5A5A5A5.
